// File: rtl/led_frame_buffer.sv
// led_frame_buffer
//   Pixel frame store feeding the LED matrix scan controller. A producer
//   streams one frame of pixels (raster order) over a valid/ready handshake.
//   The scan controller reads through a 1-cycle registered address/data port.
//
//   Build option LED_FB_DOUBLE_BUFFER_EN:
//     defined   - two banks. Writes fill the back bank, and the banks swap
//                 only on i_frame_sync, so a partial frame is never shown.
//     undefined - one bank. Writes land in the displayed bank (tearing is
//                 allowed), and o_wr_ready stays high outside reset.
//
//   Ports
//     i_clk, rst      clock; synchronous active-high reset
//     i_wr_data       pixel {B,G,R}, 3*PWM_BITS wide
//     i_wr_valid      producer has a pixel
//     i_wr_last       final pixel of a frame (qualified by i_wr_valid)
//     o_wr_ready      a pixel is accepted this cycle
//     i_rd_addr       read address = row*MATRIX_COLS + col
//     o_rd_data       front-bank pixel for the address of the previous cycle
//     i_frame_sync    display-side safe swap point (one-cycle pulse)
//     o_front_bank    bank currently displayed
//     o_swap          one-cycle pulse after a swap takes effect
//     o_len_err       one-cycle pulse when frame length and i_wr_last disagree
module led_frame_buffer #(
  parameter int MATRIX_COLS = 64,
  parameter int MATRIX_ROWS = 32,
  parameter int PWM_BITS    = 1,
  localparam int NPIX       = MATRIX_COLS * MATRIX_ROWS,
  localparam int AW         = $clog2(NPIX),
  localparam int DW         = 3 * PWM_BITS
) (
  input  logic          i_clk,
  input  logic          rst,
  input  logic [DW-1:0] i_wr_data,
  input  logic          i_wr_valid,
  input  logic          i_wr_last,
  output logic          o_wr_ready,
  input  logic [AW-1:0] i_rd_addr,
  output logic [DW-1:0] o_rd_data,
  input  logic          i_frame_sync,
  output logic          o_front_bank,
  output logic          o_swap,
  output logic          o_len_err
);

  localparam logic [AW-1:0] LAST_PTR = AW'(NPIX - 1);
  localparam logic [AW:0]   NPIX_W   = (AW + 1)'(NPIX);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic          wr_ready_q, wr_ready_d;
  logic          len_err_q, len_err_d;
  logic [DW-1:0] rd_data_q;

  logic          wr_beat;
  logic          at_last;
  logic          frame_done;
  logic          rd_in_range;

  assign wr_beat     = i_wr_valid && wr_ready_q && !rst;
  assign at_last     = (wr_ptr_q == LAST_PTR);
  // A frame completes on i_wr_last or when the last address is written.
  assign frame_done  = wr_beat && (i_wr_last || at_last);
  assign rd_in_range = ({1'b0, i_rd_addr} < NPIX_W);

`ifdef LED_FB_DOUBLE_BUFFER_EN

  typedef enum logic [0:0] {
    FILL      = 1'b0,
    WAIT_SWAP = 1'b1
  } state_t;

  state_t state_q, state_d;
  logic   front_q, front_d;
  logic   swap_q, swap_d;

  // Bank select is the address MSB: the back bank is always ~front.
  logic [DW-1:0] mem [0:(2**(AW+1))-1];
  logic [AW:0]   wr_idx;
  logic [AW:0]   rd_idx;

  assign wr_idx = {~front_q, wr_ptr_q};
  assign rd_idx = {front_q, i_rd_addr};

  // Next-state logic for the fill/swap sequencer and the write pointer.
  always_comb begin
    state_d   = state_q;
    front_d   = front_q;
    swap_d    = 1'b0;
    wr_ptr_d  = wr_ptr_q;
    len_err_d = 1'b0;
    case (state_q)
      FILL: begin
        // i_frame_sync here (even alongside the completing beat) is ignored.
        if (frame_done) begin
          wr_ptr_d  = '0;
          len_err_d = i_wr_last ^ at_last;
          state_d   = WAIT_SWAP;
        end else if (wr_beat) begin
          wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
          wr_ptr_d = wr_ptr_q;
        end
      end
      WAIT_SWAP: begin
        if (i_frame_sync) begin
          front_d = ~front_q;
          swap_d  = 1'b1;
          state_d = FILL;
        end else begin
          state_d = WAIT_SWAP;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
    // Registered ready tracks the state being entered.
    wr_ready_d = (state_d == FILL);
  end

  // Sequencer state, bank select and swap pulse registers.
  always_ff @(posedge i_clk) begin
    if (rst) begin
      state_q <= FILL;
      front_q <= 1'b0;
      swap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      front_q <= front_d;
      swap_q  <= swap_d;
    end
  end

  assign o_front_bank = front_q;
  assign o_swap       = swap_q;

  logic unused_nothing;
  assign unused_nothing = 1'b0;

`else

  logic [DW-1:0] mem [0:NPIX-1];
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;

  assign wr_idx = wr_ptr_q;
  assign rd_idx = i_rd_addr;

  // Write pointer: completing a frame rewinds it immediately.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    len_err_d  = 1'b0;
    wr_ready_d = 1'b1;
    if (frame_done) begin
      wr_ptr_d  = '0;
      len_err_d = i_wr_last ^ at_last;
    end else if (wr_beat) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
  end

  // Single bank: there is no swap point to honour.
  logic unused_frame_sync;
  assign unused_frame_sync = i_frame_sync;

  assign o_front_bank = 1'b0;
  assign o_swap       = 1'b0;

`endif

  // Write pointer, ready and length-error registers.
  always_ff @(posedge i_clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      wr_ready_q <= 1'b0;
      len_err_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      wr_ready_q <= wr_ready_d;
      len_err_q  <= len_err_d;
    end
  end

  // Pixel array write port; contents are deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (wr_beat) begin
      mem[wr_idx] <= i_wr_data;
    end
  end

  // Read port kept as a plain clocked read so the array maps onto block RAM
  // with its (resettable) output register. Out-of-range addresses return 0.
  always_ff @(posedge i_clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (rd_in_range) begin
      rd_data_q <= mem[rd_idx];
    end else begin
      rd_data_q <= '0;
    end
  end

  assign o_wr_ready = wr_ready_q;
  assign o_rd_data  = rd_data_q;
  assign o_len_err  = len_err_q;

endmodule

// File: tb/tb_led_frame_buffer.sv
// Scoreboard bench for led_frame_buffer (default 64x32, 3-bit pixels).
// Stimulus pushes expected read data and length-error values into queues; a
// monitor on the falling edge pops and compares them when the DUT presents
// the corresponding output, and also watches ready/front/swap every cycle.
module tb_led_frame_buffer;

`ifdef LED_FB_DOUBLE_BUFFER_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif
  localparam int NPIX = 2048;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  i_wr_data = 3'b000;
  logic        i_wr_valid = 1'b0;
  logic        i_wr_last = 1'b0;
  logic        o_wr_ready;
  logic [10:0] i_rd_addr = 11'd0;
  logic [2:0]  o_rd_data;
  logic        i_frame_sync = 1'b0;
  logic        o_front_bank;
  logic        o_swap;
  logic        o_len_err;

  led_frame_buffer dut (
    .i_clk       (clk),
    .rst         (rst),
    .i_wr_data   (i_wr_data),
    .i_wr_valid  (i_wr_valid),
    .i_wr_last   (i_wr_last),
    .o_wr_ready  (o_wr_ready),
    .i_rd_addr   (i_rd_addr),
    .o_rd_data   (o_rd_data),
    .i_frame_sync(i_frame_sync),
    .o_front_bank(o_front_bank),
    .o_swap      (o_swap),
    .o_len_err   (o_len_err)
  );

  always #5 clk = ~clk;

  // Reference state
  bit [2:0]  m_mem [0:4095];
  int        m_ptr = 0;
  bit        m_front = 1'b0;
  bit        m_waiting = 1'b0;
  bit        exp_ready = 1'b0;
  bit        exp_front = 1'b0;
  bit        exp_swap = 1'b0;
  bit        run_en = 1'b0;

  // Scoreboard
  logic [2:0] rd_q [$];
  bit         len_q [$];
  bit         rd_req = 1'b0, done_req = 1'b0;
  bit         rd_chk = 1'b0, len_chk = 1'b0;
  int         n_checks = 0;
  int         n_pass = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Latch which checks are due after this edge.
  always @(posedge clk) begin
    rd_chk  <= rd_req;
    len_chk <= done_req;
  end

  // Monitor: compare DUT outputs away from the active edge.
  always @(negedge clk) begin
    if (run_en) begin
      if (rd_chk) begin
        if (rd_q.size() == 0) check("rd_q_underflow", 32'd1, 32'd0);
        else check("rd_data", {29'd0, o_rd_data}, {29'd0, rd_q.pop_front()});
      end
      if (len_chk) begin
        if (len_q.size() == 0) check("len_q_underflow", 32'd1, 32'd0);
        else check("len_err", {31'd0, o_len_err}, {31'd0, len_q.pop_front()});
      end else begin
        check("len_err_idle", {31'd0, o_len_err}, 32'd0);
      end
      check("wr_ready", {31'd0, o_wr_ready}, {31'd0, exp_ready});
      check("front_bank", {31'd0, o_front_bank}, {31'd0, exp_front});
      check("swap", {31'd0, o_swap}, {31'd0, exp_swap});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    exp_swap = 1'b0;
  endtask

  task automatic wr(input logic [2:0] d, input bit last);
    bit done;
    bit back;
    back = DB ? ~m_front : 1'b0;
    done = last || (m_ptr == NPIX - 1);
    i_wr_valid = 1'b1;
    i_wr_data  = d;
    i_wr_last  = last;
    done_req   = done;
    if (done) len_q.push_back(last != (m_ptr == NPIX - 1));
    m_mem[{back, 11'(m_ptr)}] = d;
    step();
    i_wr_valid = 1'b0;
    i_wr_last  = 1'b0;
    done_req   = 1'b0;
    m_ptr = done ? 0 : m_ptr + 1;
    if (done && DB) begin
      m_waiting = 1'b1;
      exp_ready = 1'b0;
    end
  endtask

  task automatic idle();
    i_wr_valid = 1'b0;
    step();
  endtask

  task automatic rd(input logic [10:0] a);
    i_rd_addr = a;
    rd_req = 1'b1;
    rd_q.push_back(m_mem[{m_front, a}]);
    step();
    rd_req = 1'b0;
  endtask

  // Pulse i_frame_sync, optionally reading in the same cycle (old bank).
  task automatic sync(input bit do_rd, input logic [10:0] a);
    bit taken;
    i_frame_sync = 1'b1;
    if (do_rd) begin
      i_rd_addr = a;
      rd_req = 1'b1;
      rd_q.push_back(m_mem[{m_front, a}]);
    end
    taken = DB && m_waiting;
    step();
    i_frame_sync = 1'b0;
    rd_req = 1'b0;
    if (taken) begin
      m_front   = ~m_front;
      m_waiting = 1'b0;
      exp_front = m_front;
      exp_swap  = 1'b1;
      exp_ready = 1'b1;
    end
  endtask

  task automatic reset_checks();
    check("rst_wr_ready", {31'd0, o_wr_ready}, 32'd0);
    check("rst_rd_data", {29'd0, o_rd_data}, 32'd0);
    check("rst_front_bank", {31'd0, o_front_bank}, 32'd0);
    check("rst_swap", {31'd0, o_swap}, 32'd0);
    check("rst_len_err", {31'd0, o_len_err}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with address 0 presented.
    rst = 1'b1;
    repeat (3) step();
    reset_checks();
    rst = 1'b0;
    step();
    check("ready_after_rst", {31'd0, o_wr_ready}, 32'd1);
    exp_ready = 1'b1;
    run_en = 1'b1;

    // Full frame with i_wr_last on the final beat, one idle gap mid-frame.
    for (int i = 0; i < NPIX; i++) begin
      if (i == 100) idle();
      wr(3'(i * 5 + 1), i == NPIX - 1);
    end
    sync(1'b0, 11'd0);
    rd(11'd2047);
    rd(11'd0);
    rd(11'd5);
    rd(11'd1234);
    rd(11'd100);

    // Full frame without i_wr_last: completes at the last address, len_err.
    for (int i = 0; i < NPIX; i++) wr(3'(i * 3 + 6), 1'b0);

`ifdef LED_FB_DOUBLE_BUFFER_EN
    // Backpressure while waiting for the swap: nothing may be written.
    i_wr_valid = 1'b1;
    i_wr_data  = 3'b110;
    i_wr_last  = 1'b1;
    repeat (100) step();
    i_wr_valid = 1'b0;
    i_wr_last  = 1'b0;
`endif

    // Read in the sync cycle (old bank), then again (new bank).
    sync(1'b1, 11'd5);
    rd(11'd5);

    // Short frame: 4 beats, pixel 3'b111 at address 3.
    wr(3'b010, 1'b0);
    wr(3'b011, 1'b0);
    wr(3'b100, 1'b0);
    wr(3'b111, 1'b1);
    rd(11'd3);
    rd(11'd4);
    sync(1'b1, 11'd0);
    rd(11'd3);
    rd(11'd4);
    rd(11'd2047);
    rd(11'd2);
    rd(11'd0);

    // Sync during FILL has no effect.
    sync(1'b0, 11'd0);

    // Single-beat frame at pointer 0.
    wr(3'b110, 1'b1);
    sync(1'b0, 11'd0);
    rd(11'd0);
    rd(11'd1);

    // Reset mid-frame at pointer 700.
    for (int i = 0; i < 700; i++) wr(3'(i ^ 3), 1'b0);
    run_en = 1'b0;
    rst = 1'b1;
    step();
    step();
    reset_checks();
    rst = 1'b0;
    m_ptr = 0;
    m_front = 1'b0;
    m_waiting = 1'b0;
    exp_front = 1'b0;
    exp_swap = 1'b0;
    step();
    exp_ready = 1'b1;
    run_en = 1'b1;
    wr(3'b101, 1'b1);
    sync(1'b0, 11'd0);
    rd(11'd0);
    rd(11'd1);
    rd(11'd699);
    rd(11'd700);

    step();
    step();
    check("rd_q_empty", rd_q.size(), 32'd0);
    check("len_q_empty", len_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/led_frame_buffer.md
# led_frame_buffer

Double-buffered pixel frame store that sits directly upstream of the LED matrix scan controller. A producer (pattern generator, UART/SPI loader) streams one full frame of pixels into the back bank over a valid/ready handshake. The scan controller reads the front bank through a 1-cycle registered address/data port. Banks swap only at a display frame boundary, so a partially written frame is never shown.

## Interface
- MATRIX_COLS, 64, panel width in pixels
- MATRIX_ROWS, 32, panel height in pixels
- PWM_BITS, 1, bits per colour channel; pixel word is 3*PWM_BITS wide, {B,G,R} from MSB to LSB, matching the scan controller
- i_clk  in  1  clock
- rst  in  1  reset; synchronous, active-high; clock i_clk
- i_wr_data  in  3*PWM_BITS  pixel to write; raster order, row 0 col 0 first
- i_wr_valid  in  1  producer has a pixel
- i_wr_last  in  1  marks the final pixel of a frame; qualified by i_wr_valid
- o_wr_ready  out  1  buffer accepts a pixel this cycle
- i_rd_addr  in  AW  read address, where AW = $clog2(MATRIX_COLS*MATRIX_ROWS); address = row*MATRIX_COLS + col
- o_rd_data  out  3*PWM_BITS  front-bank pixel at the address presented one cycle earlier
- i_frame_sync  in  1  one-cycle pulse from the display side marking a safe swap point (end of last row scan)
- o_front_bank  out  1  index of the bank currently displayed
- o_swap  out  1  one-cycle pulse in the cycle after a swap takes effect
- o_len_err  out  1  one-cycle pulse when the frame length and i_wr_last disagree

## Operation
- Storage: 2 banks × NPIX words, where NPIX = MATRIX_COLS*MATRIX_ROWS. Bank = address MSB; inferred as block RAM. Contents are not reset.
- Write beat: i_wr_valid && o_wr_ready. It writes the back bank (~o_front_bank) at wr_ptr, then wr_ptr increments.
- FSM states:
  - FILL: o_wr_ready=1. A beat with i_wr_last, or a beat at wr_ptr==NPIX-1, completes the frame: wr_ptr←0 and go to WAIT_SWAP.
  - WAIT_SWAP: o_wr_ready=0. On i_frame_sync: o_front_bank toggles, o_swap pulses next cycle, go to FILL.
- Length errors pulse o_len_err in the cycle after the completing beat:
  - Early i_wr_last (wr_ptr < NPIX-1): frame completes short. The remaining back-bank words keep stale content.
  - Beat at NPIX-1 without i_wr_last: frame completes anyway.
- Read: o_rd_data ← mem[{o_front_bank, i_rd_addr}] every cycle. There is no enable. Addresses ≥ NPIX return 0.

## Timing
- Reset values:
  - o_rd_data=0, o_wr_ready=0 while rst is high, o_front_bank=0, o_swap=0, o_len_err=0.
  - State=FILL, wr_ptr=0.
  - o_wr_ready rises in the first cycle after rst deasserts.
- Read latency: exactly 1 cycle, address at cycle N → data at N+1. This matches the scan controller's address-then-sample pattern.
- Swap boundary: a read issued in the cycle i_frame_sync is sampled returns old-bank data. Reads from the next cycle onward use the new bank.
- i_frame_sync in the same cycle as the completing write beat is ignored. The swap waits for the next i_frame_sync.
- i_frame_sync during FILL has no effect.
- Reset mid-frame: wr_ptr→0 and bank→0; partial data is discarded logically.
- Write throughput: 1 pixel per cycle in FILL.

## Configuration
- LED_FB_DOUBLE_BUFFER_EN defined: the two-bank behaviour described above.
- LED_FB_DOUBLE_BUFFER_EN undefined:
  - Single bank of NPIX words; writes go straight to the displayed bank (tearing allowed).
  - No WAIT_SWAP state: o_wr_ready=1 whenever not in reset, and completing a frame returns wr_ptr to 0 immediately.
  - i_frame_sync is ignored, o_front_bank is tied 0, o_swap is tied 0.
  - o_len_err is unchanged.

## Test plan
- Reset, then read address 0 → o_rd_data=0 and o_front_bank=0; o_wr_ready=1 one cycle after rst falls.
- Write 2048 beats of 3'b001 with i_wr_last on the last → o_wr_ready=0 and no o_len_err. Pulse i_frame_sync → o_swap pulses and o_front_bank=1. Read address 2047 → 3'b001 one cycle later.
- Swap-edge read: issue read addr 5 in the i_frame_sync cycle → old-bank data returned. Read addr 5 on the next cycle → new-bank data.
- Short frame of 10 beats with i_wr_last on beat 10 → o_len_err pulse and WAIT_SWAP. After swap, addresses 10–2047 hold the bank's previous content.
- Backpressure: hold i_wr_valid high in WAIT_SWAP for 100 cycles → no writes and wr_ptr stays 0. Then rst mid-FILL at wr_ptr=700 → wr_ptr=0, o_front_bank=0.
- Build without LED_FB_DOUBLE_BUFFER_EN: write pixel 3'b111 to addr 3, then read addr 3 → 3'b111 one cycle later with no i_frame_sync; o_wr_ready never drops after reset.
